obi_rr_arbiter: RTL and testbench

- Shares one OBI subordinate port (e.g. the input of an OBI cut or a peripheral bus) between NumReq OBI managers.
- Arbitration is round-robin with a lock that holds an ungranted request stable until it is granted.
- Tracks up to MaxTrans outstanding transactions and routes the in-order responses back to the issuing requester.
- Sits in the SoC interconnect in front of shared slaves (student-area bus, peripheral subsystem).

---
 rtl/obi_arb_pkg.sv | 18 +
 rtl/obi_arb_id_fifo.sv | 54 +++++
 rtl/obi_rr_arbiter.sv | 112 +++++++++++
 tb/tb_obi_rr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/obi_arb_pkg.sv
// Shared helpers and types for the OBI round-robin arbiter.
// Width helpers keep degenerate parameter values (one requester, one slot) legal.
package obi_arb_pkg;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_e;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order ID queue remembering which requester owns each outstanding transaction.
// The head entry is visible combinationally so responses route with zero latency.
module obi_arb_id_fifo
    import obi_arb_pkg::*;
#(
    parameter int Depth = 2,
    parameter int Width = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push,
    input  logic [Width-1:0]            wdata,
    input  logic                        pop,
    output logic [Width-1:0]            rdata,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(Depth)-1:0] count
);
    localparam int PtrW = idx_width(Depth);
    localparam int CntW = cnt_width(Depth);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;
    logic [CntW-1:0]  cnt;
    logic             do_push, do_pop;

    assign full    = (cnt == CntW'(Depth));
    assign empty   = (cnt == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI subordinate port among NumReq managers,
// with request locking for OBI stability and in-order response routing.
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int MaxTrans  = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               sbr_req_i,
    output logic [NumReq-1:0]               sbr_gnt_o,
    input  logic [NumReq*AddrWidth-1:0]     sbr_addr_i,
    input  logic [NumReq-1:0]               sbr_we_i,
    input  logic [NumReq*DataWidth/8-1:0]   sbr_be_i,
    input  logic [NumReq*DataWidth-1:0]     sbr_wdata_i,
    output logic [NumReq-1:0]               sbr_rvalid_o,
    output logic [DataWidth-1:0]            sbr_rdata_o,
    output logic                            sbr_err_o,
    output logic                            mgr_req_o,
    input  logic                            mgr_gnt_i,
    output logic [AddrWidth-1:0]            mgr_addr_o,
    output logic                            mgr_we_o,
    output logic [DataWidth/8-1:0]          mgr_be_o,
    output logic [DataWidth-1:0]            mgr_wdata_o,
    input  logic                            mgr_rvalid_i,
    input  logic [DataWidth-1:0]            mgr_rdata_i,
    input  logic                            mgr_err_i,
    output logic [$clog2(MaxTrans+1)-1:0]   outstanding_o,
    output logic                            spurious_o
);
    localparam int IdxW = idx_width(NumReq);
    localparam int CntW = cnt_width(MaxTrans);
    localparam int BeW  = DataWidth / 8;

    arb_state_e      state_q;
    logic [IdxW-1:0] ptr_q, lock_idx_q, winner, cand, head;
    logic [CntW-1:0] count;
    logic            found, fifo_full, fifo_empty, hs, pop, spurious_q;

    // Scan from the pointer; a locked request overrides the scan result.
    always_comb begin
        winner = ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = IdxW'((int'(ptr_q) + i) % NumReq);
            if (!found && sbr_req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        if (state_q == LOCKED) winner = lock_idx_q;
    end

    assign mgr_req_o = ~rst_i & (|sbr_req_i) & ~fifo_full;
    assign hs        = mgr_req_o & mgr_gnt_i;
    assign pop       = ~rst_i & mgr_rvalid_i & ~fifo_empty;

    always_comb begin
        sbr_gnt_o    = '0;
        sbr_rvalid_o = '0;
        if (hs)  sbr_gnt_o[winner]  = 1'b1;
        if (pop) sbr_rvalid_o[head] = 1'b1;
    end

    assign mgr_addr_o    = rst_i ? '0 : sbr_addr_i[winner*AddrWidth +: AddrWidth];
    assign mgr_we_o      = rst_i ? 1'b0 : sbr_we_i[winner];
    assign mgr_be_o      = rst_i ? '0 : sbr_be_i[winner*BeW +: BeW];
    assign mgr_wdata_o   = rst_i ? '0 : sbr_wdata_i[winner*DataWidth +: DataWidth];
    assign sbr_rdata_o   = rst_i ? '0 : mgr_rdata_i;
    assign sbr_err_o     = ~rst_i & mgr_err_i;
    assign outstanding_o = rst_i ? '0 : count;
    assign spurious_o    = ~rst_i & spurious_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= UNLOCKED;
            lock_idx_q <= '0;
            ptr_q      <= '0;
            spurious_q <= 1'b0;
        end else begin
            spurious_q <= mgr_rvalid_i & fifo_empty;
            if (hs) begin
                ptr_q   <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + 1'b1;
                state_q <= UNLOCKED;
            end else if (mgr_req_o) begin
                // Presented but not granted: pin this requester until it is taken.
                state_q    <= LOCKED;
                lock_idx_q <= winner;
            end
        end
    end

    obi_arb_id_fifo #(
        .Depth (MaxTrans),
        .Width (IdxW)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (hs),
        .wdata (winner),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: directed scenarios plus a randomized run
// compared against a queue-based model of the arbitration and response rules.
module tb_obi_rr_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MT = 2;
    localparam int CW = $clog2(MT + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      gnt_o;
    logic [N*AW-1:0]   addr = '0;
    logic [N-1:0]      we = '0;
    logic [N*DW/8-1:0] be = '0;
    logic [N*DW-1:0]   wdata = '0;
    logic [N-1:0]      rvalid_o;
    logic [DW-1:0]     rdata_o;
    logic              err_o;
    logic              mgr_req;
    logic              mgr_gnt = 1'b0;
    logic [AW-1:0]     mgr_addr;
    logic              mgr_we;
    logic [DW/8-1:0]   mgr_be;
    logic [DW-1:0]     mgr_wdata;
    logic              mgr_rvalid = 1'b0;
    logic [DW-1:0]     mgr_rdata = '0;
    logic              mgr_err = 1'b0;
    logic [CW-1:0]     outstanding;
    logic              spurious;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    obi_rr_arbiter #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(MT)) dut (
        .clk_i(clk), .rst_i(rst),
        .sbr_req_i(req), .sbr_gnt_o(gnt_o), .sbr_addr_i(addr), .sbr_we_i(we),
        .sbr_be_i(be), .sbr_wdata_i(wdata), .sbr_rvalid_o(rvalid_o),
        .sbr_rdata_o(rdata_o), .sbr_err_o(err_o),
        .mgr_req_o(mgr_req), .mgr_gnt_i(mgr_gnt), .mgr_addr_o(mgr_addr), .mgr_we_o(mgr_we),
        .mgr_be_o(mgr_be), .mgr_wdata_o(mgr_wdata), .mgr_rvalid_i(mgr_rvalid),
        .mgr_rdata_i(mgr_rdata), .mgr_err_i(mgr_err),
        .outstanding_o(outstanding), .spurious_o(spurious)
    );

    // Reference model: queue of owner IDs, next-priority index, locked requester (-1 = none).
    int   q[$];
    int   m_ptr  = 0;
    int   m_lock = -1;
    bit   m_spur = 0;
    bit   exp_req;
    int   exp_win;
    logic [N-1:0] exp_gnt, exp_rv;

    task automatic model_eval();
        bit found = 0;
        exp_win = 0;
        if (m_lock >= 0) begin
            exp_win = m_lock;
        end else begin
            for (int i = 0; i < N; i++) begin
                int k = (m_ptr + i) % N;
                if (!found && req[k]) begin
                    exp_win = k;
                    found = 1;
                end
            end
        end
        exp_req = !rst && (req != 0) && (q.size() < MT);
        exp_gnt = (exp_req && mgr_gnt) ? N'(1 << exp_win) : '0;
        exp_rv  = (!rst && mgr_rvalid && q.size() > 0) ? N'(1 << q[0]) : '0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ptr = 0; m_lock = -1; m_spur = 0;
        end else begin
            model_eval();
            m_spur = mgr_rvalid && (q.size() == 0);
            if (mgr_rvalid && q.size() > 0) void'(q.pop_front());
            if (exp_req && mgr_gnt) begin
                q.push_back(exp_win);
                m_ptr  = (exp_win + 1) % N;
                m_lock = -1;
            end else if (exp_req) begin
                m_lock = exp_win;
            end
        end
    end

    task automatic clear_inputs();
        req = '0; mgr_gnt = 0; mgr_rvalid = 0; mgr_rdata = '0; mgr_err = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; clear_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic test_reset();
        rst = 1; req = '1; mgr_gnt = 1; mgr_rvalid = 1; mgr_rdata = 32'hA5A5_5A5A; mgr_err = 1;
        for (int k = 0; k < N; k++) addr[k*AW +: AW] = 32'h2000_0000 + k;
        settle();
        n_tests++; if ({mgr_req, gnt_o, rvalid_o, err_o} !== '0) begin n_fail++;
            $display("FAIL reset_ctrl: got req=%b gnt=%b rv=%b err=%b, need all 0", mgr_req, gnt_o, rvalid_o, err_o); end
        n_tests++; if (rdata_o !== '0 || mgr_addr !== '0) begin n_fail++;
            $display("FAIL reset_data: got rdata=%h addr=%h, need 0", rdata_o, mgr_addr); end
        n_tests++; if (outstanding !== '0 || spurious !== 1'b0) begin n_fail++;
            $display("FAIL reset_regs: got outstanding=%0d spurious=%b, need 0/0", outstanding, spurious); end
        @(negedge clk);
        rst = 0; clear_inputs();
        settle();
        n_tests++; if (outstanding !== '0 || spurious !== 1'b0 || mgr_req !== 1'b0) begin n_fail++;
            $display("FAIL post_reset: got outstanding=%0d spurious=%b req=%b, need 0/0/0", outstanding, spurious, mgr_req); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; addr[0 +: AW] = 32'h1000_0004; mgr_gnt = 1;
        settle();
        n_tests++; if (mgr_addr !== 32'h1000_0004 || gnt_o !== 4'b0001 || mgr_req !== 1'b1) begin n_fail++;
            $display("FAIL single_req: got addr=%h gnt=%b req=%b, need 10000004/0001/1", mgr_addr, gnt_o, mgr_req); end
        @(negedge clk);
        req = '0; mgr_gnt = 0; mgr_rvalid = 1; mgr_rdata = 32'hDEAD_BEEF;
        settle();
        n_tests++; if (rvalid_o !== 4'b0001 || rdata_o !== 32'hDEAD_BEEF || outstanding !== CW'(1)) begin n_fail++;
            $display("FAIL single_rsp: got rv=%b rdata=%h out=%0d, need 0001/deadbeef/1", rvalid_o, rdata_o, outstanding); end
        @(negedge clk);
        mgr_rvalid = 0;
        settle();
        n_tests++; if (outstanding !== '0 || spurious !== 1'b0) begin n_fail++;
            $display("FAIL single_drain: got out=%0d spur=%b, need 0/0", outstanding, spurious); end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int k = 0; k < N; k++) addr[k*AW +: AW] = 32'h3000_0000 + 32'(k * 16);
        for (int c = 0; c <= 8; c++) begin
            req = (c < 8) ? 4'b1111 : 4'b0000;
            mgr_gnt = (c < 8);
            mgr_rvalid = (c > 0);
            mgr_rdata = 32'(c);
            settle();
            if (c < 8) begin
                n_tests++; if (gnt_o !== 4'(1 << (c % 4)) || mgr_addr !== 32'h3000_0000 + 32'((c % 4) * 16)) begin n_fail++;
                    $display("FAIL fair_gnt[%0d]: got gnt=%b addr=%h, need %b", c, gnt_o, mgr_addr, 4'(1 << (c % 4))); end
            end
            if (c > 0) begin
                n_tests++; if (rvalid_o !== 4'(1 << ((c - 1) % 4))) begin n_fail++;
                    $display("FAIL fair_rsp[%0d]: got rv=%b, need %b", c, rvalid_o, 4'(1 << ((c - 1) % 4))); end
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        for (int k = 0; k < N; k++) addr[k*AW +: AW] = 32'h4000_0000 + 32'(k * 4);
        for (int c = 0; c < 3; c++) begin
            req = (c == 0) ? 4'b0100 : 4'b0101; mgr_gnt = 0;
            settle();
            n_tests++; if (mgr_req !== 1'b1 || mgr_addr !== 32'h4000_0008 || gnt_o !== '0) begin n_fail++;
                $display("FAIL lock_hold[%0d]: got req=%b addr=%h gnt=%b, need 1/40000008/0000", c, mgr_req, mgr_addr, gnt_o); end
            @(negedge clk);
        end
        req = 4'b0101; mgr_gnt = 1;
        settle();
        n_tests++; if (gnt_o !== 4'b0100) begin n_fail++;
            $display("FAIL lock_gnt: got gnt=%b, need 0100", gnt_o); end
        @(negedge clk);
        req = 4'b1001; mgr_rvalid = 1;
        settle();
        n_tests++; if (gnt_o !== 4'b1000 || rvalid_o !== 4'b0100) begin n_fail++;
            $display("FAIL lock_next3: got gnt=%b rv=%b, need 1000/0100", gnt_o, rvalid_o); end
        @(negedge clk);
        req = 4'b0001;
        settle();
        n_tests++; if (gnt_o !== 4'b0001 || rvalid_o !== 4'b1000) begin n_fail++;
            $display("FAIL lock_next0: got gnt=%b rv=%b, need 0001/1000", gnt_o, rvalid_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_full();
        do_reset();
        req = 4'b0011; mgr_gnt = 1;
        settle();
        n_tests++; if (gnt_o !== 4'b0001) begin n_fail++; $display("FAIL full_g0: got %b, need 0001", gnt_o); end
        @(negedge clk);
        settle();
        n_tests++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL full_g1: got %b, need 0010", gnt_o); end
        @(negedge clk);
        settle();
        n_tests++; if (mgr_req !== 1'b0 || gnt_o !== '0 || outstanding !== CW'(2)) begin n_fail++;
            $display("FAIL full_block: got req=%b gnt=%b out=%0d, need 0/0000/2", mgr_req, gnt_o, outstanding); end
        @(negedge clk);
        mgr_rvalid = 1;
        settle();
        n_tests++; if (mgr_req !== 1'b0 || rvalid_o !== 4'b0001) begin n_fail++;
            $display("FAIL full_pop: got req=%b rv=%b, need 0/0001", mgr_req, rvalid_o); end
        @(negedge clk);
        mgr_rvalid = 0;
        settle();
        n_tests++; if (mgr_req !== 1'b1 || outstanding !== CW'(1) || gnt_o !== 4'b0001) begin n_fail++;
            $display("FAIL full_free: got req=%b out=%0d gnt=%b, need 1/1/0001", mgr_req, outstanding, gnt_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_spurious_reset();
        do_reset();
        req = 4'b0001; mgr_gnt = 1;
        @(negedge clk);
        @(negedge clk);
        settle();
        n_tests++; if (outstanding !== CW'(2)) begin n_fail++;
            $display("FAIL sp_fill: got out=%0d, need 2", outstanding); end
        rst = 1; clear_inputs();
        @(negedge clk);
        rst = 0; mgr_rvalid = 1;
        settle();
        n_tests++; if (outstanding !== '0 || rvalid_o !== '0 || spurious !== 1'b0) begin n_fail++;
            $display("FAIL sp_after_rst: got out=%0d rv=%b spur=%b, need 0/0000/0", outstanding, rvalid_o, spurious); end
        @(negedge clk);
        mgr_rvalid = 0;
        settle();
        n_tests++; if (spurious !== 1'b1 || outstanding !== '0) begin n_fail++;
            $display("FAIL sp_pulse: got spur=%b out=%0d, need 1/0", spurious, outstanding); end
        @(negedge clk);
        settle();
        n_tests++; if (spurious !== 1'b0) begin n_fail++;
            $display("FAIL sp_one_cycle: got spur=%b, need 0", spurious); end
    endtask

    task automatic test_push_pop();
        do_reset();
        req = 4'b0010; mgr_gnt = 1;
        @(negedge clk);
        req = 4'b0100; mgr_rvalid = 1;
        settle();
        n_tests++; if (outstanding !== CW'(1) || gnt_o !== 4'b0100 || rvalid_o !== 4'b0010) begin n_fail++;
            $display("FAIL pp_same: got out=%0d gnt=%b rv=%b, need 1/0100/0010", outstanding, gnt_o, rvalid_o); end
        @(negedge clk);
        req = '0; mgr_gnt = 0;
        settle();
        n_tests++; if (outstanding !== CW'(1) || rvalid_o !== 4'b0100) begin n_fail++;
            $display("FAIL pp_after: got out=%0d rv=%b, need 1/0100", outstanding, rvalid_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req = N'($urandom);
            mgr_gnt = ($urandom_range(0, 3) != 0);
            mgr_rvalid = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            mgr_rdata = $urandom; mgr_err = 1'($urandom);
            addr = {$urandom, $urandom, $urandom, $urandom};
            wdata = {$urandom, $urandom, $urandom, $urandom};
            we = N'($urandom); be = 16'($urandom);
            settle();
            n_tests++; if (mgr_req !== exp_req || gnt_o !== exp_gnt || rvalid_o !== exp_rv) begin n_fail++;
                $display("FAIL rnd_ctrl[%0d]: got req=%b gnt=%b rv=%b, need %b/%b/%b", c, mgr_req, gnt_o, rvalid_o, exp_req, exp_gnt, exp_rv); end
            if (exp_req) begin
                n_tests++;
                if (mgr_addr !== addr[exp_win*AW +: AW] || mgr_we !== we[exp_win] ||
                    mgr_be !== be[exp_win*4 +: 4] || mgr_wdata !== wdata[exp_win*DW +: DW]) begin n_fail++;
                    $display("FAIL rnd_mux[%0d]: got addr=%h we=%b be=%h wd=%h, need requester %0d fields", c, mgr_addr, mgr_we, mgr_be, mgr_wdata, exp_win); end
            end
            n_tests++; if (rdata_o !== mgr_rdata || err_o !== mgr_err) begin n_fail++;
                $display("FAIL rnd_rsp[%0d]: got rdata=%h err=%b, need %h/%b", c, rdata_o, err_o, mgr_rdata, mgr_err); end
            n_tests++; if (outstanding !== CW'(q.size()) || spurious !== m_spur) begin n_fail++;
                $display("FAIL rnd_regs[%0d]: got out=%0d spur=%b, need %0d/%b", c, outstanding, spurious, q.size(), m_spur); end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_full();
        test_spurious_reset();
        test_push_pop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
